// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit shared definitions
// op codes, FSM states and divider constants
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

  localparam int DIV_CYCLES = 32;
  localparam int DIV_CW     = $clog2(DIV_CYCLES);

endpackage

// File: rtl/mul_div_unit_div_radix2_core.sv
// div_radix2_core: unsigned restoring divider
// one quotient bit per cycle, DIV_CYCLES steps
module div_radix2_core
  import mul_div_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0]      rem_q, rem_d;
  logic [W-1:0]      quo_q, quo_d;
  logic [DIV_CW-1:0] cnt_q, cnt_d;
  logic              run_q, run_d;

  logic [W:0] rem_sh;
  logic [W:0] diff;
  logic       ge;
  logic       last;

  // one shift/subtract step; divisor 0 yields all-ones quotient
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, divisor};
    ge     = ~diff[W];
    last   = (cnt_q == DIV_CW'(DIV_CYCLES - 1));
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      rem_d = '0;
      quo_d = dividend;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = ge ? diff[W-1:0] : rem_sh[W-1:0];
      quo_d = {quo_q[W-2:0], ge};
      cnt_d = cnt_q + DIV_CW'(1);
      if (last) run_d = 1'b0;
    end
  end

  // divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done      = run_q & last & ~abort;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU in EXE
// stalls the front end via busy, holds {HI,LO} until advance
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  input  logic              exe_advance,
  output logic              busy,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam int PD = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int PW = 2 * DATA_W;

  md_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d;
  logic [DATA_W-1:0] res_lo_q, res_lo_d;
  logic              res_valid_q, res_valid_d;
  logic [PW-1:0]     pipe_q [PD];
  logic [PW-1:0]     pipe_d [PD];

  md_op_t            op_e;
  logic              is_sgn;
  logic              is_div;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [PW-1:0]     mul_mag;
  logic [PW-1:0]     mul_prod;
  logic [PW-1:0]     mul_res;
  logic              div_start;
  logic              div_done;
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_rem;
  logic              div_zero;
  logic [DATA_W-1:0] q_fix;
  logic [DATA_W-1:0] r_fix;
  logic              busy_c;

  // operand decode: signed ops work on magnitudes
  always_comb begin
    op_e   = md_op_t'(op);
    is_sgn = (op_e == MD_MULT) || (op_e == MD_DIV);
    is_div = (op_e == MD_DIV) || (op_e == MD_DIVU);
    a_neg  = is_sgn & src_a[DATA_W-1];
    b_neg  = is_sgn & src_b[DATA_W-1];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;
  end

  // multiplier datapath and its pipeline registers
  always_comb begin
    mul_mag  = PW'(a_q) * PW'(b_q);
    mul_prod = (sa_q ^ sb_q) ? -mul_mag : mul_mag;
    pipe_d[0] = mul_prod;
    for (int i = 1; i < PD; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    mul_res = (MUL_LAT > 1) ? pipe_q[PD-1] : mul_prod;
  end

  // division sign fix; a zero divisor keeps raw core output
  always_comb begin
    div_zero = (b_q == '0);
    q_fix = (~div_zero & (sa_q ^ sb_q)) ? -div_quo : div_quo;
    r_fix = (~div_zero & sa_q) ? -div_rem : div_rem;
  end

  div_radix2_core #(
    .W(DATA_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (flush),
    .dividend (a_mag),
    .divisor  (b_q),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // next-state and output logic; flush overrides everything
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    res_valid_d = res_valid_q;
    busy_c      = 1'b0;
    div_start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_c = op_valid & ~flush;
        if (busy_c) begin
          a_d       = a_mag;
          b_d       = b_mag;
          sa_d      = a_neg;
          sb_d      = b_neg;
          cnt_d     = '0;
          div_start = is_div;
          state_d   = is_div ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        busy_c = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_LAT - 1)) begin
          res_hi_d    = mul_res[PW-1:DATA_W];
          res_lo_d    = mul_res[DATA_W-1:0];
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DIV: begin
        busy_c = 1'b1;
        if (div_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy_c      = 1'b1;
        res_hi_d    = r_fix;
        res_lo_d    = q_fix;
        res_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (exe_advance) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (flush) begin
      state_d     = ST_IDLE;
      res_hi_d    = res_hi_q;
      res_lo_d    = res_lo_q;
      res_valid_d = 1'b0;
      div_start   = 1'b0;
    end
  end

  // state, operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      res_valid_q <= 1'b0;
      for (int i = 0; i < PD; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_valid_q <= res_valid_d;
      for (int i = 0; i < PD; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign busy      = busy_c & ~rst;
  assign res_valid = res_valid_q;
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU execution unit in the EXE stage.
- Drives the `DIVMULTBusy` input of the write/flush control block, which stalls PC/IF-ID/ID-EXE while it is high.
- Delivers the 64-bit {HI,LO} result to the HI/LO write path.
- Aborts cleanly on an exception flush of EXE and holds its result until the pipeline actually advances.

Parameters:
- MUL_LAT, 2, cycles spent in MUL state (registered multiplier pipeline depth, >=1)
- DATA_W, 32, operand width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op_valid  in  1  EXE holds a mul/div instruction
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- src_a  in  32  rs value (dividend / multiplicand)
- src_b  in  32  rt value (divisor / multiplier)
- flush  in  1  EXE flush (exception); aborts operation
- exe_advance  in  1  EXE_Wr from flush control; instruction leaves EXE this cycle
- busy  out  1  to DIVMULTBusy; stall request
- res_valid  out  1  result available
- res_hi  out  32  HI result (remainder / product high)
- res_lo  out  32  LO result (quotient / product low)

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous, active-high.
- Reset: state=IDLE, res_valid=0, res_hi=0, res_lo=0, counter=0. busy=0 while rst is high.
- States: IDLE, MUL, DIV, FIX, DONE.

State transitions:
- IDLE: busy = op_valid & ~flush (combinational). When busy=1, latch operands:
  - Signed ops: store |a|, |b| plus sign flags.
  - Unsigned ops: store raw values.
  - Clear counter; go to MUL (op 0/1) or DIV (op 2/3).
- MUL: busy=1. Product is computed in a registered pipeline over MUL_LAT cycles; counter counts to MUL_LAT-1.
  - Result = 64-bit signed (MULT) or unsigned (MULTU) product.
  - Write {res_hi,res_lo} and go to DONE.
- DIV: busy=1. Radix-2 restoring step, one quotient bit per cycle, 32 cycles (counter 0..31), then FIX.
- FIX: busy=1.
  - Quotient negated if sign_a^sign_b; remainder takes the sign of the dividend (signed ops only).
  - Write res_lo=quotient, res_hi=remainder; go to DONE.
- DONE: busy=0, res_valid=1.
  - exe_advance=1 or flush=1: go to IDLE, res_valid=0 next cycle.
  - Otherwise hold DONE. No restart even while op_valid stays high, e.g. during a cache stall.

Latency and cycle counts:
- DIV/DIVU: busy high 34 cycles (issue + 32 + FIX); res_valid first high in cycle 34.
- MULT/MULTU: busy high 1+MUL_LAT cycles.
- Back-to-back: after DONE+advance, the next instruction is seen in IDLE the following cycle. No bubble beyond that one IDLE issue cycle.

Boundary conditions:
- flush: has priority in every state. Next state is IDLE; busy drops the same cycle in IDLE, next cycle otherwise. res_hi/res_lo are not updated. res_valid=0.
- Divide by zero (src_b==0): skip sign fix. res_lo=0xFFFFFFFF, res_hi=src_a as latched. Latency is unchanged (34).
- DIV 0x80000000 / 0xFFFFFFFF: res_lo=0x80000000, res_hi=0.
- rst mid-operation: immediate IDLE; all outputs return to reset values.
- res_hi/res_lo change only on entry to DONE; they hold the last value otherwise.

Decomposition:
- Shared package (CPU defines): md_op_t enum (MULT/MULTU/DIV/DIVU), md_state_t enum, DIV_CYCLES=32.
- One sub-module: div_radix2_core. Holds the 64-bit remainder/quotient shift register and counter; ports start, dividend, divisor, done, quotient, remainder, abort.
- Multiplier stays inline.

Test Plan:
- DIVU src_a=100, src_b=7 -> busy high exactly 34 cycles; then res_valid=1, res_lo=14, res_hi=2.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF.
- MULT 0xFFFFFFFF*2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands -> hi=1, lo=0xFFFFFFFE. busy high 3 cycles each.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started, flush at DIV counter=10 -> state IDLE next cycle; res_valid never rises; res_hi/lo keep previous values. A new DIVU 9/3 then gives lo=3, hi=0.
- DONE with exe_advance=0 for 5 cycles, op_valid=1 -> res_valid stays 1, busy stays 0, no re-issue. exe_advance=1 -> IDLE; a following MULTU issues the next cycle.
